param_cache_ctrl: RTL

Parametrised direct-mapped, write-through, no-write-allocate cache with an integrated miss-handling FSM. It serves one CPU-side port (I or D cache) and refills whole blocks from unified memory one word per handshake. It owns its tag/valid and data storage and keeps saturating hit and miss counters. It replaces fixed-geometry cache instances in which the fill sequencing is driven from outside.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_miss_fsm.sv | 153 +++++++++++++++
 rtl/param_cache_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through cache.
// An address splits into {tag, idx, word, byte}; the byte bit is ignored.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    WDONE = 2'd3
  } state_e;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  function automatic int off_w(input int words);
    return $clog2(words) + 1;
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words);
    return addr_w - idx_w(lines) - off_w(words);
  endfunction

endpackage

// File: rtl/cache_miss_fsm.sv
// Miss/write sequencer: captures the request, drives the single memory port and
// emits data/tag/valid write strobes for the arrays held by the top level.
module cache_miss_fsm
  import cache_pkg::*;
#(
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 16,
  parameter  int LINES  = 128,
  parameter  int WORDS  = 8,
  localparam int OFF_W  = off_w(WORDS),
  localparam int IDX_W  = idx_w(LINES),
  localparam int WRD_W  = OFF_W - 1,
  localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:1] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              hit_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              data_we_o,
  output logic [IDX_W-1:0]  data_idx_o,
  output logic [WRD_W-1:0]  data_word_o,
  output logic [DATA_W-1:0] data_wdat_o,
  output logic              tag_we_o,
  output logic [IDX_W-1:0]  tag_idx_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              inv_o,
  output logic              hit_inc_o,
  output logic              miss_inc_o
);

  state_e              state_q, state_d;
  logic [WRD_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:1]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic                fdone_q, fdone_d;

  logic [IDX_W-1:0]    cap_idx;
  assign cap_idx = addr_q[OFF_W+IDX_W-1:OFF_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= MEM_RD;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      req_q   <= req_d;
      we_q    <= we_d;
      fdone_q <= fdone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    req_d       = req_q;
    we_d        = we_q;
    fdone_d     = 1'b0;
    stall_o     = 1'b0;
    data_we_o   = 1'b0;
    data_idx_o  = cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
    data_word_o = cpu_addr_i[OFF_W-1:1];
    data_wdat_o = cpu_wdata_i;
    tag_we_o    = 1'b0;
    inv_o       = 1'b0;
    hit_inc_o   = 1'b0;
    miss_inc_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o = cpu_wr_i | (cpu_rd_i & ~hit_i);
        if (cpu_wr_i) begin
          state_d   = WRITE;
          addr_d    = cpu_addr_i;
          wdat_d    = cpu_wdata_i;
          req_d     = 1'b1;
          we_d      = MEM_WR;
          data_we_o = hit_i;
        end else if (cpu_rd_i) begin
          if (hit_i) begin
            // The first hit after a refill is the retiring miss, not a new hit.
            hit_inc_o = ~fdone_q;
          end else begin
            state_d    = FILL;
            addr_d     = cpu_addr_i;
            cnt_d      = '0;
            req_d      = 1'b1;
            we_d       = MEM_RD;
            inv_o      = 1'b1;
            miss_inc_o = 1'b1;
          end
        end
      end
      FILL: begin
        stall_o     = 1'b1;
        data_idx_o  = cap_idx;
        data_word_o = cnt_q;
        data_wdat_o = mem_rdata_i;
        if (mem_ack_i) begin
          data_we_o = 1'b1;
          cnt_d     = cnt_q + WRD_W'(1);
          if (cnt_q == WRD_W'(WORDS - 1)) begin
            tag_we_o = 1'b1;
            req_d    = 1'b0;
            fdone_d  = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      WRITE: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          req_d   = 1'b0;
          we_d    = MEM_RD;
          state_d = WDONE;
        end
      end
      WDONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdat_q;
  assign mem_addr_o  = (state_q == FILL) ? {addr_q[ADDR_W-1:OFF_W], cnt_q, 1'b0}
                                         : {addr_q, 1'b0};
  assign tag_idx_o   = cap_idx;
  assign tag_o       = addr_q[ADDR_W-1:OFF_W+IDX_W];

endmodule

// File: rtl/param_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache with block refill and
// saturating hit/miss counters; sequencing lives in cache_miss_fsm.
module param_cache_ctrl
  import cache_pkg::*;
#(
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 16,
  parameter  int LINES  = 128,
  parameter  int WORDS  = 8,
  parameter  int CNT_W  = 16,
  localparam int OFF_W  = off_w(WORDS),
  localparam int IDX_W  = idx_w(LINES),
  localparam int WRD_W  = OFF_W - 1,
  localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [WRD_W-1:0]  cpu_word;
  logic              addr_lsb_unused;

  assign cpu_tag         = cpu_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign cpu_idx         = cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign cpu_word        = cpu_addr_i[OFF_W-1:1];
  assign addr_lsb_unused = cpu_addr_i[0];

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

  logic              hit;
  logic              data_we, tag_we, inv, hit_inc, miss_inc;
  logic [IDX_W-1:0]  data_idx, tag_idx;
  logic [WRD_W-1:0]  data_word;
  logic [DATA_W-1:0] data_wdat;
  logic [TAG_W-1:0]  tag_wdat;

  assign hit         = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign cpu_rdata_o = cpu_rd_i ? data_q[cpu_idx][cpu_word] : '0;

  cache_miss_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (LINES),
    .WORDS  (WORDS)
  ) u_fsm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cpu_rd_i    (cpu_rd_i),
    .cpu_wr_i    (cpu_wr_i),
    .cpu_addr_i  (cpu_addr_i[ADDR_W-1:1]),
    .cpu_wdata_i (cpu_wdata_i),
    .hit_i       (hit),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .data_we_o   (data_we),
    .data_idx_o  (data_idx),
    .data_word_o (data_word),
    .data_wdat_o (data_wdat),
    .tag_we_o    (tag_we),
    .tag_idx_o   (tag_idx),
    .tag_o       (tag_wdat),
    .inv_o       (inv),
    .hit_inc_o   (hit_inc),
    .miss_inc_o  (miss_inc)
  );

  // A line is invalidated at miss entry so an aborted refill never looks valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[tag_idx] <= 1'b1;
    end else if (inv) begin
      valid_q[cpu_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tag_we) begin
      tag_q[tag_idx] <= tag_wdat;
    end
    if (data_we) begin
      data_q[data_idx][data_word] <= data_wdat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      if (miss_inc && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule
